// File: rtl/pc_flag_ctrl.sv
// pc_flag_ctrl: program-counter and FLAG-register owner for the WISC-F23
// single-cycle core. Receives per-bit flag writes from the ALU, resolves
// B/BR condition codes against the registered FLAG, and selects next PC
// (sequential, PC-relative branch, register branch, HLT hold, stall hold).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   opcode     in   [3:0]  instruction opcode
//   ccc        in   [2:0]  branch condition code
//   imm9       in   [8:0]  signed branch offset in words
//   br_target  in   [15:0] register target for BR
//   flag_in    in   [2:0]  ALU flags {N,Z,V}
//   flag_en    in   [2:0]  per-bit flag write enable {N,Z,V}
//   stall      in   hold PC and FLAG this cycle
//   pc         out  [15:0] current fetch address
//   pc_plus2   out  [15:0] pc + PC_STEP
//   taken      out  current B/BR condition is true
//   flags      out  [2:0]  registered FLAG {N,Z,V}
//   halted     out  HLT retired, core frozen until reset
module pc_flag_ctrl #(
  parameter logic [15:0] PC_RESET = 16'h0000,
  parameter logic [15:0] PC_STEP  = 16'd2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  opcode,
  input  logic [2:0]  ccc,
  input  logic [8:0]  imm9,
  input  logic [15:0] br_target,
  input  logic [2:0]  flag_in,
  input  logic [2:0]  flag_en,
  input  logic        stall,
  output logic [15:0] pc,
  output logic [15:0] pc_plus2,
  output logic        taken,
  output logic [2:0]  flags,
  output logic        halted
);

  localparam logic [3:0] OP_B   = 4'hC;
  localparam logic [3:0] OP_BR  = 4'hD;
  localparam logic [3:0] OP_HLT = 4'hF;

  // Condition evaluation against the registered FLAG {N,Z,V}.
  function automatic logic cond_met(input logic [2:0] c, input logic [2:0] f);
    logic n, z, v;
    n = f[2];
    z = f[1];
    v = f[0];
    case (c)
      3'b000:  cond_met = !z;
      3'b001:  cond_met = z;
      3'b010:  cond_met = !z && !n;
      3'b011:  cond_met = n;
      3'b100:  cond_met = z || (!z && !n);
      3'b101:  cond_met = n || z;
      3'b110:  cond_met = v;
      default: cond_met = 1'b1;
    endcase
  endfunction

  logic signed [15:0] br_off;
  logic        [15:0] target_b;
  logic               is_branch;

  // Word offset becomes a byte offset: sign-extend then shift left by one.
  assign br_off    = {{6{imm9[8]}}, imm9, 1'b0};
  assign pc_plus2  = pc + PC_STEP;
  assign target_b  = pc_plus2 + $unsigned(br_off);
  assign is_branch = (opcode == OP_B) || (opcode == OP_BR);
  assign taken     = cond_met(ccc, flags) && is_branch && !halted;

  // Architectural state update. A branch sees the FLAG value from before
  // this edge; a flag write on the same edge only affects later instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc     <= PC_RESET;
      flags  <= 3'b000;
      halted <= 1'b0;
    end else if (!halted && !stall) begin
      for (int i = 0; i < 3; i++) begin
        if (flag_en[i]) flags[i] <= flag_in[i];
      end
      if (opcode == OP_HLT) begin
        halted <= 1'b1;
      end else if ((opcode == OP_B) && taken) begin
        pc <= target_b;
      end else if ((opcode == OP_BR) && taken) begin
        pc <= br_target;
      end else begin
        pc <= pc_plus2;
      end
    end
  end

endmodule

// File: tb/tb_pc_flag_ctrl.sv
module tb_pc_flag_ctrl;

  logic        clk;
  logic        rst_n;
  logic [3:0]  opcode;
  logic [2:0]  ccc;
  logic [8:0]  imm9;
  logic [15:0] br_target;
  logic [2:0]  flag_in;
  logic [2:0]  flag_en;
  logic        stall;
  logic [15:0] pc;
  logic [15:0] pc_plus2;
  logic        taken;
  logic [2:0]  flags;
  logic        halted;

  int total = 0;
  int bad   = 0;

  pc_flag_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .opcode    (opcode),
    .ccc       (ccc),
    .imm9      (imm9),
    .br_target (br_target),
    .flag_in   (flag_in),
    .flag_en   (flag_en),
    .stall     (stall),
    .pc        (pc),
    .pc_plus2  (pc_plus2),
    .taken     (taken),
    .flags     (flags),
    .halted    (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [3:0] op, input logic [2:0] c, input logic [8:0] im,
                           input logic [2:0] fi, input logic [2:0] fe);
    opcode  = op;
    ccc     = c;
    imm9    = im;
    flag_in = fi;
    flag_en = fe;
  endtask

  initial begin
    logic [7:0] exp_tbl;

    rst_n     = 1'b0;
    stall     = 1'b0;
    br_target = 16'h0000;
    set_instr(4'h0, 3'b000, 9'h000, 3'b000, 3'b000);
    tick();
    tick();
    chk("rst_pc", pc, 16'h0000);
    chk("rst_pc_plus2", pc_plus2, 16'h0002);
    chk("rst_flags", flags, 3'b000);
    chk("rst_halted", halted, 1'b0);

    rst_n = 1'b1;
    tick(); chk("seq_pc1", pc, 16'h0002);
    tick(); chk("seq_pc2", pc, 16'h0004);
    tick(); chk("seq_pc3", pc, 16'h0006);
    chk("seq_flags", flags, 3'b000);
    chk("seq_halted", halted, 1'b0);

    repeat (4) tick();
    chk("pc_0e", pc, 16'h000E);

    // ADD writes Z
    set_instr(4'h0, 3'b000, 9'h000, 3'b010, 3'b111);
    tick();
    chk("add_pc", pc, 16'h0010);
    chk("add_flags", flags, 3'b010);

    // B EQ +4 words at 0x0010 -> 0x0012 + 8
    set_instr(4'hC, 3'b001, 9'h004, 3'b000, 3'b000);
    #1 chk("beq_taken", taken, 1'b1);
    tick();
    chk("beq_pc", pc, 16'h001A);

    // B NE with a same-edge flag write: decided on old Z=1, not taken
    set_instr(4'hC, 3'b000, 9'h010, 3'b000, 3'b111);
    #1 chk("bne_taken", taken, 1'b0);
    tick();
    chk("bne_pc", pc, 16'h001C);
    chk("bne_flags", flags, 3'b000);

    // Restore Z, then partial write of Z only
    set_instr(4'h0, 3'b000, 9'h000, 3'b010, 3'b111);
    tick();
    chk("add2_flags", flags, 3'b010);
    set_instr(4'h0, 3'b000, 9'h000, 3'b101, 3'b010);
    tick();
    chk("xor_pc", pc, 16'h0020);
    chk("xor_flags", flags, 3'b000);

    // B OV with V=0: falls through
    set_instr(4'hC, 3'b110, 9'h010, 3'b000, 3'b000);
    #1 chk("bov_taken", taken, 1'b0);
    tick();
    chk("bov_pc", pc, 16'h0022);

    // Full condition table with flags=000
    exp_tbl = 8'b10010101;
    for (int c = 0; c < 8; c++) begin
      set_instr(4'hC, 3'(c), 9'h000, 3'b000, 3'b000);
      #1 chk($sformatf("cond000_%0d", c), taken, exp_tbl[c]);
    end
    set_instr(4'h0, 3'b111, 9'h000, 3'b000, 3'b000);
    #1 chk("nonbranch_taken", taken, 1'b0);

    // B always, imm9=-1 word: self loop at 0x0022
    set_instr(4'hC, 3'b111, 9'h1FF, 3'b000, 3'b000);
    tick();
    chk("selfloop_pc", pc, 16'h0022);

    // Load N and V, check table again
    set_instr(4'h0, 3'b000, 9'h000, 3'b101, 3'b111);
    tick();
    chk("nv_flags", flags, 3'b101);
    exp_tbl = 8'b11101001;
    for (int c = 0; c < 8; c++) begin
      set_instr(4'hD, 3'(c), 9'h000, 3'b000, 3'b000);
      #1 chk($sformatf("cond101_%0d", c), taken, exp_tbl[c]);
    end

    // BR always to 0xBEEF, then to 0xFFFE, then wrap
    br_target = 16'hBEEF;
    set_instr(4'hD, 3'b111, 9'h000, 3'b000, 3'b000);
    tick();
    chk("br_pc", pc, 16'hBEEF);
    br_target = 16'hFFFE;
    tick();
    chk("br_pc_fffe", pc, 16'hFFFE);
    chk("wrap_pc_plus2", pc_plus2, 16'h0000);
    set_instr(4'h0, 3'b000, 9'h000, 3'b000, 3'b000);
    tick();
    chk("wrap_pc", pc, 16'h0000);

    // Stall two cycles during an ADD
    stall = 1'b1;
    set_instr(4'h0, 3'b000, 9'h000, 3'b110, 3'b111);
    tick(); tick();
    chk("stall_pc", pc, 16'h0000);
    chk("stall_flags", flags, 3'b101);
    stall = 1'b0;
    tick();
    chk("unstall_pc", pc, 16'h0002);
    chk("unstall_flags", flags, 3'b110);

    // Go to 0x0040 and halt; first with stall held
    br_target = 16'h0040;
    set_instr(4'hD, 3'b111, 9'h000, 3'b000, 3'b000);
    tick();
    chk("br40_pc", pc, 16'h0040);
    set_instr(4'hF, 3'b000, 9'h000, 3'b000, 3'b000);
    stall = 1'b1;
    tick();
    chk("hlt_stall_halted", halted, 1'b0);
    chk("hlt_stall_pc", pc, 16'h0040);
    stall = 1'b0;
    tick();
    chk("hlt_halted", halted, 1'b1);
    chk("hlt_pc", pc, 16'h0040);

    set_instr(4'hC, 3'b111, 9'h020, 3'b001, 3'b111);
    #1 chk("halted_taken", taken, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("frozen_pc_%0d", k), pc, 16'h0040);
    end
    chk("frozen_flags", flags, 3'b110);
    chk("frozen_halted", halted, 1'b1);

    // Asynchronous reset pulse mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc, 16'h0000);
    chk("arst_halted", halted, 1'b0);
    chk("arst_flags", flags, 3'b000);
    rst_n = 1'b1;
    set_instr(4'h0, 3'b000, 9'h000, 3'b000, 3'b000);
    tick();
    chk("post_rst_pc", pc, 16'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pc_flag_ctrl.md
Name: pc_flag_ctrl

Overview:
- Consumer end of the ALU flag interface for the WISC-F23 single-cycle processor.
- Holds the architectural FLAG register (N, Z, V), written per-bit from the ALU's flags/enable outputs.
- Resolves B/BR condition codes against that register and owns the PC register: next-PC select, HLT and stall handling.
- Sits between the ALU and instruction-fetch address.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, byte increment per sequential instruction.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  4  current instruction [15:12]
- ccc  in  3  branch condition [11:9]
- imm9  in  9  signed branch offset in words [8:0]
- br_target  in  16  register value for BR
- flag_in  in  3  ALU flags: [2]=N, [1]=Z, [0]=V
- flag_en  in  3  ALU per-bit flag write enable, same bit order
- stall  in  1  hold PC and FLAG this cycle (fetch/memory not ready)
- pc  out  16  current PC (fetch address)
- pc_plus2  out  16  pc + PC_STEP (used by PCS writeback)
- taken  out  1  current B/BR condition true
- flags  out  3  registered FLAG {N,Z,V}
- halted  out  1  HLT retired; processor frozen

Behaviour:
- Reset (rst_n low, asynchronous): pc=PC_RESET, flags=3'b000, halted=0.
  - Outputs derived combinationally from these regs (pc_plus2=PC_RESET+2).
- All arithmetic is 16-bit modulo 2^16; wrap is silent (16'hFFFE+2 = 16'h0000).
- Branch offset: sign-extend imm9 to 16 bits, shift left 1.
  - target_b = pc_plus2 + (sext(imm9)<<1).
- Condition decode (ccc) uses registered flags only, never flag_in:
  - 000 NE: Z=0
  - 001 EQ: Z=1
  - 010 GT: Z=0 & N=0
  - 011 LT: N=1
  - 100 GE: Z=1 | (Z=0 & N=0)
  - 101 LE: N=1 | Z=1
  - 110 OV: V=1
  - 111 always
- taken = cond & (opcode==4'hC | opcode==4'hD) & !halted. Combinational; 0 otherwise.
- Next PC, priority order:
  - halted or stall: hold.
  - opcode 4'hF (HLT): hold; halted<=1.
  - opcode 4'hC and taken: target_b.
  - opcode 4'hD and taken: br_target.
  - else: pc_plus2.
- FLAG update on each rising edge when !stall & !halted:
  - flags[i] <= flag_en[i] ? flag_in[i] : flags[i], for i=0..2.
  - Bits with enable 0 retain value. Enable 3'b000 (branch, mem, HLT) leaves FLAG untouched.
- Same edge as a branch: the branch already evaluated on the old flags. A flag write that edge affects only the next instruction; there is no forwarding.
- HLT latency: halted rises on the edge where HLT is present and !stall. PC stays at the HLT address.
- halted is sticky; only rst_n clears it. Once halted, all inputs are ignored.
- stall and HLT together: HLT is not retired until stall drops.
- Reset asserted mid-operation overrides everything immediately. The first edge after release performs normal fetch from PC_RESET.
- Latency: PC and FLAG update one edge after inputs; taken and pc_plus2 have zero latency.

Test Plan:
- Reset then 3 edges with opcode=4'h0, flag_en=0 -> pc 0x0000, 0x0002, 0x0004, 0x0006; flags=000; halted=0.
- ADD writes flag_in=3'b010, flag_en=3'b111; next instr B ccc=001, imm9=9'h004 at pc=0x0010 -> taken=1; next pc=0x001A.
- flags=010; XOR with flag_en=3'b010, flag_in=000, then B ccc=110 -> N and V unchanged, Z=0; taken=0; pc advances by 2.
- B ccc=111, imm9=9'h1FF at pc=0x0020 -> pc=0x0020 (self loop). BR ccc=111, br_target=0xBEEF -> pc=0xBEEF. pc=0xFFFE, sequential -> pc=0x0000.
- stall=1 for 2 cycles during an ADD with flag_en=111 -> pc and flags unchanged; update applies on the first edge with stall=0.
- HLT at pc=0x0040 -> halted=1 after one edge; pc stays 0x0040 for 5 more edges despite B/flag inputs. rst_n pulse low mid-cycle -> pc=0, halted=0 immediately.
